// File: rtl/load_store_unit.sv
// Load/store unit between the CPU request port and a synchronous-read DataMemory.
// Sub-word stores are performed as read-modify-write; loads are lane-selected and extended.
module load_store_unit #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [DATA_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_a,
   output logic [DATA_WIDTH-1:0] mem_wd,
   input  logic [DATA_WIDTH-1:0] mem_rd
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] RD_REQ  = 3'd1;
   localparam logic [2:0] RD_DATA = 3'd2;
   localparam logic [2:0] WR      = 3'd3;
   localparam logic [2:0] RESP    = 3'd4;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   logic [2:0]            state, state_n;
   logic                  req_ready_n, mem_we_n, resp_valid_n, resp_err_n;
   logic [DATA_WIDTH-1:0] mem_a_n, resp_rdata_n;
   logic                  accept, misalign;

   logic                  we_q, uns_q;
   logic [1:0]            size_q, off_q;
   logic [DATA_WIDTH-1:0] wdata_q;

   // Lane select plus sign/zero extension of a read word.
   function automatic logic [31:0] fmt_load(input logic [31:0] rd, input logic [1:0] size,
                                            input logic [1:0] off, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      b = rd[{off, 3'b000} +: 8];
      h = off[1] ? rd[31:16] : rd[15:0];
      case (size)
         SZ_BYTE: return uns ? {24'd0, b} : {{24{b[7]}}, b};
         SZ_HALF: return uns ? {16'd0, h} : {{16{h[15]}}, h};
         default: return rd;
      endcase
   endfunction

   // Overwrite only the addressed lane(s) of the read word.
   function automatic logic [31:0] merge_store(input logic [31:0] rd, input logic [31:0] wd,
                                               input logic [1:0] size, input logic [1:0] off);
      logic [31:0] m;
      m = rd;
      if (size == SZ_BYTE) m[{off, 3'b000} +: 8] = wd[7:0];
      else                 m[{off[1], 4'b0000} +: 16] = wd[15:0];
      return m;
   endfunction

   assign accept = req_valid && (state == IDLE);

   always_comb begin
      misalign = 1'b0;
      case (req_size)
         SZ_HALF: misalign = req_addr[0];
         SZ_WORD: misalign = |req_addr[1:0];
         SZ_ILL:  misalign = 1'b1;
         default: misalign = 1'b0;
      endcase
   end

   // The merged store word depends on mem_rd, which only arrives during RD_DATA.
   assign mem_wd = !mem_we         ? '0 :
                   (state == WR)   ? wdata_q :
                   merge_store(mem_rd, wdata_q, size_q, off_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         mem_we     <= 1'b0;
         mem_a      <= '0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
      end else begin
         state      <= state_n;
         req_ready  <= req_ready_n;
         mem_we     <= mem_we_n;
         mem_a      <= mem_a_n;
         resp_valid <= resp_valid_n;
         resp_err   <= resp_err_n;
         resp_rdata <= resp_rdata_n;
      end
   end

   always_comb begin
      state_n      = state;
      req_ready_n  = 1'b0;
      mem_we_n     = 1'b0;
      mem_a_n      = mem_a;
      resp_valid_n = 1'b0;
      resp_err_n   = 1'b0;
      resp_rdata_n = resp_rdata;
      case (state)
         IDLE: begin
            if (req_valid) begin
               mem_a_n = {2'b00, req_addr[DATA_WIDTH-1:2]};
               if (misalign) begin
                  state_n      = RESP;
                  resp_valid_n = 1'b1;
                  resp_err_n   = 1'b1;
               end else if (req_we && (req_size == SZ_WORD)) begin
                  state_n  = WR;
                  mem_we_n = 1'b1;
               end else begin
                  state_n = RD_REQ;
               end
            end
         end
         RD_REQ: begin
            state_n  = RD_DATA;
            mem_we_n = we_q;
         end
         RD_DATA: begin
            state_n      = RESP;
            resp_valid_n = 1'b1;
            if (!we_q) resp_rdata_n = fmt_load(mem_rd, size_q, off_q, uns_q);
         end
         WR: begin
            state_n      = RESP;
            resp_valid_n = 1'b1;
         end
         RESP: begin
            state_n = IDLE;
            mem_a_n = '0;
         end
         default: begin
            state_n = IDLE;
            mem_a_n = '0;
         end
      endcase
      req_ready_n = (state_n == IDLE);
   end

   // Request capture; req_* are only looked at on the accepting edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         size_q  <= 2'b00;
         off_q   <= 2'b00;
         wdata_q <= '0;
      end else if (accept) begin
         we_q    <= req_we;
         uns_q   <= req_unsigned;
         size_q  <= req_size;
         off_q   <= req_addr[1:0];
         wdata_q <= req_wdata;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-array reference model, directed timing
// checks, reset abort, back-pressure and randomized traffic.
module tb_load_store_unit;

   localparam int unsigned NWORDS = 64;
   localparam int unsigned NBYTES = 256;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err, mem_we;
   logic [31:0] resp_rdata, mem_a, mem_wd, mem_rd;

   always #5 clk = ~clk;

   load_store_unit #(.DATA_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
      .mem_rd(mem_rd)
   );

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   logic [7:0]  ref_mem [NBYTES];
   logic [31:0] dmem [NWORDS];
   logic        preload;
   logic [31:0] last_load;
   exp_t        exp_q [$];
   exp_t        mon_e;
   int          n_cmp = 0, n_fail = 0;
   int          wr_exp = 0, wr_seen = 0, proto_bad = 0;
   int unsigned cyc = 0, accept_cyc = 0;

   // Synchronous-read DataMemory; preload copies the reference bytes in.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < NWORDS; i++)
            dmem[i] <= {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
      end else begin
         if (mem_we) dmem[mem_a[5:0]] <= mem_wd;
         mem_rd <= dmem[mem_a[5:0]];
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference model: little-endian byte memory, alignment rules, extension.
   task automatic model(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, output exp_t e);
      int          n;
      logic [31:0] v;
      logic [7:0]  idx;
      n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      e.err = (size == 2'd3) || ((addr % n) != 0);
      e.rdata = last_load;
      if (!e.err) begin
         if (we) begin
            for (int i = 0; i < n; i++) begin
               idx = addr[7:0] + 8'(i);
               ref_mem[idx] = wdata[8*i +: 8];
            end
            wr_exp++;
         end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) begin
               idx = addr[7:0] + 8'(i);
               v = v | (32'(ref_mem[idx]) << (8*i));
            end
            if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
            last_load = v;
            e.rdata = v;
         end
      end
   endtask

   // Drive a request and return just after the accepting edge.
   task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input bit keep, input bit push, output int waits);
      exp_t e;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      waits = 0;
      while (!req_ready && waits < 20) begin
         @(negedge clk);
         waits++;
      end
      if (!req_ready) begin
         n_cmp++; n_fail++;
         $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles", waits);
         req_valid = 1'b0;
      end else begin
         @(posedge clk);
         accept_cyc = cyc;
         if (push) begin
            model(we, size, uns, addr, wdata, e);
            exp_q.push_back(e);
         end
         if (!keep) #1 req_valid = 1'b0;
      end
   endtask

   // Monitor: pops the scoreboard on each response and watches bus protocol.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (mem_we) wr_seen++;
         if (!mem_we && mem_wd != 32'd0) proto_bad++;
         if (req_ready && mem_a != 32'd0) proto_bad++;
         if (resp_valid) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL unexpected_resp: resp_valid=1 err=%0b with nothing outstanding", resp_err);
            end else begin
               mon_e = exp_q.pop_front();
               check("resp_err", 32'(resp_err), 32'(mon_e.err));
               check("resp_rdata", resp_rdata, mon_e.rdata);
            end
         end
      end
   end

   int          w0, w1;
   int unsigned t0;
   logic        r_we, r_uns, r_keep;
   logic [1:0]  r_size;
   logic [31:0] r_addr;

   initial begin
      rst_n = 1'b0; preload = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; last_load = 32'd0;
      for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'($urandom);

      @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_err", 32'(resp_err), 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_a", mem_a, 32'd0);
      check("rst_mem_wd", mem_wd, 32'd0);
      preload = 1'b1;
      @(negedge clk);
      preload = 1'b0;
      rst_n = 1'b1;

      // Word store timing
      issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, w0);
      @(negedge clk);
      check("sw_c1_mem_we", 32'(mem_we), 32'd1);
      check("sw_c1_mem_a", mem_a, 32'd4);
      check("sw_c1_mem_wd", mem_wd, 32'hDEADBEEF);
      check("sw_c1_resp_valid", 32'(resp_valid), 32'd0);
      @(negedge clk);
      check("sw_c2_resp_valid", 32'(resp_valid), 32'd1);
      check("sw_c2_resp_err", 32'(resp_err), 32'd0);

      // Sub-word loads of 0xDEADBEEF, response in cycle 3
      issue(1'b0, 2'b00, 1'b0, 32'h13, 32'd0, 1'b0, 1'b1, w0);
      repeat (2) @(negedge clk);
      check("lb_c2_resp_valid", 32'(resp_valid), 32'd0);
      @(negedge clk);
      check("lb_c3_resp_valid", 32'(resp_valid), 32'd1);
      check("lb_rdata", resp_rdata, 32'hFFFFFFDE);
      issue(1'b0, 2'b00, 1'b1, 32'h11, 32'd0, 1'b0, 1'b1, w0);
      repeat (3) @(negedge clk);
      check("lbu_rdata", resp_rdata, 32'h000000BE);
      issue(1'b0, 2'b01, 1'b0, 32'h10, 32'd0, 1'b0, 1'b1, w0);
      repeat (3) @(negedge clk);
      check("lh_rdata", resp_rdata, 32'hFFFFBEEF);

      // Half store as read-modify-write
      issue(1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234, 1'b0, 1'b1, w0);
      @(negedge clk);
      check("sh_c1_mem_we", 32'(mem_we), 32'd0);
      @(negedge clk);
      check("sh_c2_mem_we", 32'(mem_we), 32'd1);
      check("sh_c2_mem_a", mem_a, 32'd4);
      check("sh_c2_mem_wd", mem_wd, 32'h1234BEEF);
      @(negedge clk);
      check("sh_c3_resp_valid", 32'(resp_valid), 32'd1);
      check("sh_keeps_rdata", resp_rdata, 32'hFFFFBEEF);
      issue(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b0, 1'b1, w0);
      repeat (3) @(negedge clk);
      check("lw_after_sh", resp_rdata, 32'h1234BEEF);

      // Error requests respond in cycle 1 without touching memory
      issue(1'b0, 2'b10, 1'b0, 32'h06, 32'd0, 1'b0, 1'b1, w0);
      @(negedge clk);
      check("lw_mis_resp_valid", 32'(resp_valid), 32'd1);
      check("lw_mis_resp_err", 32'(resp_err), 32'd1);
      issue(1'b1, 2'b11, 1'b0, 32'h20, 32'h5555AAAA, 1'b0, 1'b1, w0);
      @(negedge clk);
      check("sz11_resp_valid", 32'(resp_valid), 32'd1);
      check("sz11_resp_err", 32'(resp_err), 32'd1);
      check("sz11_mem_we", 32'(mem_we), 32'd0);

      // Reset during RD_REQ of a byte store aborts it
      issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000A5, 1'b0, 1'b0, w0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_mem_we", 32'(mem_we), 32'd0);
      check("abort_req_ready", 32'(req_ready), 32'd1);
      check("abort_resp_valid", 32'(resp_valid), 32'd0);
      check("abort_resp_rdata", resp_rdata, 32'd0);
      last_load = 32'd0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("abort_req_ready_after", 32'(req_ready), 32'd1);

      // Back-pressure: req_valid held across two requests
      issue(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b1, 1'b1, w0);
      t0 = accept_cyc;
      issue(1'b0, 2'b00, 1'b1, 32'h12, 32'd0, 1'b0, 1'b1, w1);
      check("bp_busy_cycles", 32'(w1), 32'd3);
      check("bp_accept_gap", 32'(accept_cyc - t0), 32'd4);
      issue(1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, 1'b1, 1'b1, w0);
      t0 = accept_cyc;
      issue(1'b0, 2'b01, 1'b0, 32'h42, 32'd0, 1'b0, 1'b1, w1);
      check("bp_sw_busy_cycles", 32'(w1), 32'd2);
      check("bp_sw_accept_gap", 32'(accept_cyc - t0), 32'd3);

      // Randomized traffic
      for (int k = 0; k < 300; k++) begin
         r_we = 1'($urandom_range(0, 1));
         r_uns = 1'($urandom_range(0, 1));
         r_size = 2'($urandom_range(0, 3));
         r_addr = 32'($urandom_range(0, NBYTES - 1));
         if ($urandom_range(0, 3) != 0) begin
            if (r_size == 2'd1) r_addr[0] = 1'b0;
            if (r_size == 2'd2) r_addr[1:0] = 2'b00;
         end
         r_keep = (k != 299) && ($urandom_range(0, 3) == 0);
         issue(r_we, r_size, r_uns, r_addr, $urandom, r_keep, 1'b1, w0);
         if (!r_keep) repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // Drain and final consistency
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      check("outstanding_at_end", 32'(exp_q.size()), 32'd0);
      check("store_write_count", 32'(wr_seen), 32'(wr_exp));
      check("protocol_violations", 32'(proto_bad), 32'd0);
      for (int i = 0; i < NWORDS; i++)
         check($sformatf("mem_word_%0d", i), dmem[i],
               {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the data and address width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port req_valid  input  1  CPU presents a memory request.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port req_unsigned  input  1  zero-extend sub-word loads when 1.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  output  32  formatted load data.
REQ-013 SHALL have port resp_err  output  1  misaligned or illegal request, valid with resp_valid.
REQ-014 SHALL have port mem_we  output  1  to DataMemory WE.
REQ-015 SHALL have port mem_a  output  32  to DataMemory A, word index = {2'b00, addr[31:2]}.
REQ-016 SHALL have port mem_wd  output  32  to DataMemory WD.
REQ-017 SHALL have port mem_rd  input  32  from DataMemory RD, registered one cycle after mem_a is sampled.

Function
REQ-018 SHALL use states IDLE, RD_REQ, RD_DATA, WR, RESP; req_ready = 1 only in IDLE.
REQ-019 SHALL accept a request on a posedge where req_valid && req_ready (cycle 0) and capture all req_* fields; req_* are ignored in all other states.
REQ-020 SHALL flag misalignment when size=01 && addr[0], size=10 && addr[1:0]!=0, or size=11; IDLE->RESP with resp_err=1 and no memory access.
REQ-021 SHALL sequence a load as IDLE->RD_REQ->RD_DATA->RESP; resp_valid is high in cycle 3.
REQ-022 SHALL sequence a word store as IDLE->WR->RESP; mem_we=1 in cycle 1; resp_valid is high in cycle 2.
REQ-023 SHALL sequence a byte/half store as read-modify-write IDLE->RD_REQ->RD_DATA(merge, mem_we=1)->RESP; resp_valid is high in cycle 3.
REQ-024 SHALL use little-endian lanes: byte k is at bits [8k+7:8k], the byte is selected by addr[1:0], and the half is selected by addr[1].
REQ-025 SHALL, on a sub-word store, replace only the addressed lane(s) of mem_rd with the low bits of req_wdata; all other bytes are unchanged.
REQ-026 SHALL sign-extend byte/half loads from the lane MSB when req_unsigned=0 and zero-extend when req_unsigned=1; word loads pass through.
REQ-027 SHALL register resp_rdata at the RD_DATA->RESP edge and hold it until the next load completes; stores leave resp_rdata unchanged.
REQ-028 SHALL assert mem_we only in WR, or in RD_DATA of a sub-word store, and for exactly one cycle per store.
REQ-029 SHALL drive mem_a with the captured word index in all non-IDLE states and 0 in IDLE; mem_wd is 0 when mem_we=0.
REQ-030 SHALL always transition RESP->IDLE; a new request is accepted at the earliest in the cycle after RESP.

Reset
REQ-031 SHALL on rst_n=0, asynchronously and regardless of state, force IDLE, mem_we=0, mem_a=0, mem_wd=0, resp_valid=0, resp_err=0, resp_rdata=0, req_ready=1.
REQ-032 SHALL abort any in-flight request when reset asserts mid-operation, with no write and no response issued afterwards.

Verification
REQ-033 SHALL test a word store: SW addr 0x10, wdata 0xDEADBEEF -> cycle 1: mem_we=1, mem_a=4, mem_wd=0xDEADBEEF; cycle 2: resp_valid=1, resp_err=0.
REQ-034 SHALL test sub-word loads with word 4 = 0xDEADBEEF: LB 0x13 -> resp_rdata 0xFFFFFFDE in cycle 3; LBU 0x11 -> 0x000000BE; LH 0x10 -> 0xFFFFBEEF.
REQ-035 SHALL test a half store: SH 0x12, wdata 0x00001234 over 0xDEADBEEF -> cycle 2: mem_we=1, mem_a=4, mem_wd=0x1234BEEF; later LW 0x10 returns 0x1234BEEF.
REQ-036 SHALL test errors: LW 0x06 and any size=11 -> cycle 1: resp_valid=1, resp_err=1; mem_we stays 0 throughout.
REQ-037 SHALL test reset mid-operation: rst_n low during RD_REQ of SB 0x11 -> mem_we=0 immediately, memory unchanged, req_ready=1, no resp_valid after release.
REQ-038 SHALL test back-pressure: req_valid held high across two requests -> the second is accepted only in the cycle after the first RESP, and req_ready=0 while busy.
